i8035_xbus_resp: RTL and testbench

- External-bus responder for the 8035 sound CPU.
- It demultiplexes the address/data bus using ALE and answers program fetches (PSENn) and MOVX reads and writes (RDn/WRn).
- It does this through two request/acknowledge memory ports: program ROM and external data.
- It sits between the CPU wrapper's strobes and data bus and the board's ROM/RAM or SDRAM arbiter. Its O_DB feeds the CPU's I_DB.

---
 rtl/i8035_xbus_resp.sv | 212 +++++++++++++++++++++
 tb/tb_i8035_xbus_resp.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/i8035_xbus_resp.sv
// External-bus responder for the 8035 sound CPU: demultiplexes AD/ALE and serves
// program fetches and MOVX reads/writes through ROM and external-data req/ack ports.
module i8035_xbus_resp #(
  parameter int unsigned PAGE_BITS = 4,
  parameter int unsigned AW        = PAGE_BITS + 8
) (
  input  logic          I_CLK,
  input  logic          I_RSTn,
  input  logic          I_ALE,
  input  logic          I_PSENn,
  input  logic          I_RDn,
  input  logic          I_WRn,
  input  logic [7:0]    I_CPU_DB,
  input  logic [7:0]    I_P2,
  output logic [7:0]    O_DB,
  output logic          O_DB_OE,
  output logic [AW-1:0] O_ROM_A,
  output logic          O_ROM_REQ,
  input  logic          I_ROM_ACK,
  input  logic [7:0]    I_ROM_D,
  output logic [AW-1:0] O_XD_A,
  output logic          O_XD_RD,
  output logic          O_XD_WR,
  output logic [7:0]    O_XD_DO,
  input  logic          I_XD_ACK,
  input  logic [7:0]    I_XD_DI,
  output logic          O_FAULT
);

  typedef enum logic [2:0] {IDLE, FETCH, XREAD, HOLD, XWRITE, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic                   ale_q, psen_q, rd_q, wr_q;
  logic [7:0]             lat_lo_q;
  logic [PAGE_BITS-1:0]   lat_pg_q;
  logic                   hold_rd_q, hold_rd_d;

  logic [7:0]             db_d;
  logic                   db_oe_d;
  logic [AW-1:0]          rom_a_d, xd_a_d;
  logic                   rom_req_d, xd_rd_d, xd_wr_d;
  logic [7:0]             xd_do_d;
  logic                   fault_d;

  logic ale_fall, psen_fall, psen_rise, rd_fall, rd_rise, wr_fall, wr_rise;
  logic any_fall, multi_fall, hold_rise, drain_ack;
  logic [AW-1:0] addr_c;

  // Upper P2 bits are not part of the address
  if (PAGE_BITS < 8) begin : g_p2_unused
    logic p2_unused;
    assign p2_unused = ^I_P2[7:PAGE_BITS];
  end

  assign ale_fall   = ale_q & ~I_ALE;
  assign psen_fall  = psen_q & ~I_PSENn;
  assign psen_rise  = ~psen_q & I_PSENn;
  assign rd_fall    = rd_q & ~I_RDn;
  assign rd_rise    = ~rd_q & I_RDn;
  assign wr_fall    = wr_q & ~I_WRn;
  assign wr_rise    = ~wr_q & I_WRn;
  assign any_fall   = psen_fall | rd_fall | wr_fall;
  assign multi_fall = (psen_fall & rd_fall) | (psen_fall & wr_fall) | (rd_fall & wr_fall);
  assign hold_rise  = hold_rd_q ? rd_rise : psen_rise;
  assign drain_ack  = (O_ROM_REQ & I_ROM_ACK) | (O_XD_RD & I_XD_ACK);
  assign addr_c     = AW'({lat_pg_q, lat_lo_q});

  // Strobe history and address latch
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      ale_q    <= 1'b0;
      psen_q   <= 1'b1;
      rd_q     <= 1'b1;
      wr_q     <= 1'b1;
      lat_lo_q <= 8'h00;
      lat_pg_q <= '0;
    end else begin
      ale_q  <= I_ALE;
      psen_q <= I_PSENn;
      rd_q   <= I_RDn;
      wr_q   <= I_WRn;
      if (ale_fall) begin
        lat_lo_q <= I_CPU_DB;
        lat_pg_q <= I_P2[PAGE_BITS-1:0];
      end
    end
  end

  // State and registered outputs
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q   <= IDLE;
      hold_rd_q <= 1'b0;
      O_DB      <= 8'hFF;
      O_DB_OE   <= 1'b0;
      O_ROM_A   <= '0;
      O_ROM_REQ <= 1'b0;
      O_XD_A    <= '0;
      O_XD_RD   <= 1'b0;
      O_XD_WR   <= 1'b0;
      O_XD_DO   <= 8'h00;
      O_FAULT   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_rd_q <= hold_rd_d;
      O_DB      <= db_d;
      O_DB_OE   <= db_oe_d;
      O_ROM_A   <= rom_a_d;
      O_ROM_REQ <= rom_req_d;
      O_XD_A    <= xd_a_d;
      O_XD_RD   <= xd_rd_d;
      O_XD_WR   <= xd_wr_d;
      O_XD_DO   <= xd_do_d;
      O_FAULT   <= fault_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d   = state_q;
    hold_rd_d = hold_rd_q;
    db_d      = O_DB;
    db_oe_d   = O_DB_OE;
    rom_a_d   = O_ROM_A;
    rom_req_d = O_ROM_REQ;
    xd_a_d    = O_XD_A;
    xd_rd_d   = O_XD_RD;
    xd_wr_d   = O_XD_WR;
    xd_do_d   = O_XD_DO;
    fault_d   = O_FAULT;

    case (state_q)
      IDLE: begin
        if (multi_fall) fault_d = 1'b1;
        if (psen_fall) begin
          rom_a_d   = addr_c;
          rom_req_d = 1'b1;
          hold_rd_d = 1'b0;
          state_d   = FETCH;
        end else if (rd_fall) begin
          xd_a_d    = addr_c;
          xd_rd_d   = 1'b1;
          hold_rd_d = 1'b1;
          state_d   = XREAD;
        end else if (wr_fall) begin
          xd_a_d  = addr_c;
          xd_do_d = I_CPU_DB;
          state_d = XWRITE;
        end
      end
      FETCH: begin
        if (I_ROM_ACK) begin
          rom_req_d = 1'b0;
          // Data arriving on the very edge the strobe ends has no one to receive it
          if (psen_rise) begin
            state_d = IDLE;
          end else begin
            db_d    = I_ROM_D;
            db_oe_d = 1'b1;
            state_d = HOLD;
          end
        end else if (psen_rise) begin
          fault_d = 1'b1;
          state_d = DRAIN;
        end
      end
      XREAD: begin
        if (I_XD_ACK) begin
          xd_rd_d = 1'b0;
          if (rd_rise) begin
            state_d = IDLE;
          end else begin
            db_d    = I_XD_DI;
            db_oe_d = 1'b1;
            state_d = HOLD;
          end
        end else if (rd_rise) begin
          fault_d = 1'b1;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        if (hold_rise) begin
          db_d    = 8'hFF;
          db_oe_d = 1'b0;
          state_d = IDLE;
        end
      end
      XWRITE: begin
        if (any_fall) fault_d = 1'b1;
        // Capture data while the strobe is low, then post the write after it ends
        if (!O_XD_WR) begin
          if (!I_WRn) xd_do_d = I_CPU_DB;
          if (wr_rise) xd_wr_d = 1'b1;
        end else if (I_XD_ACK) begin
          xd_wr_d = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (any_fall) fault_d = 1'b1;
        if (drain_ack) begin
          rom_req_d = 1'b0;
          xd_rd_d   = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i8035_xbus_resp.sv
// Directed table-driven bench for i8035_xbus_resp: one row per clock of stimulus
// with the full expected output vector after that clock edge.
module tb_i8035_xbus_resp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ale, psen_n, rd_n, wr_n;
  logic [7:0]  cpu_db, p2;
  logic [7:0]  db;
  logic        db_oe;
  logic [11:0] rom_a;
  logic        rom_req, rom_ack;
  logic [7:0]  rom_d;
  logic [11:0] xd_a;
  logic        xd_rd, xd_wr, xd_ack;
  logic [7:0]  xd_do, xd_di;
  logic        fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i8035_xbus_resp #(.PAGE_BITS(4), .AW(12)) dut (
    .I_CLK(clk), .I_RSTn(rst_n), .I_ALE(ale), .I_PSENn(psen_n), .I_RDn(rd_n),
    .I_WRn(wr_n), .I_CPU_DB(cpu_db), .I_P2(p2), .O_DB(db), .O_DB_OE(db_oe),
    .O_ROM_A(rom_a), .O_ROM_REQ(rom_req), .I_ROM_ACK(rom_ack), .I_ROM_D(rom_d),
    .O_XD_A(xd_a), .O_XD_RD(xd_rd), .O_XD_WR(xd_wr), .O_XD_DO(xd_do),
    .I_XD_ACK(xd_ack), .I_XD_DI(xd_di), .O_FAULT(fault)
  );

  typedef struct {
    string       name;
    logic        ale, psen_n, rd_n, wr_n;
    logic [7:0]  cpu_db, p2;
    logic        rom_ack;
    logic [7:0]  rom_d;
    logic        xd_ack;
    logic [7:0]  xd_di;
    logic [44:0] exp;
  } vec_t;

  vec_t tbl[$];
  vec_t post[$];

  // Expected output vector: {db, oe, rom_a, rom_req, xd_a, xd_rd, xd_wr, xd_do, fault}
  function automatic logic [44:0] ex(logic [7:0] e_db, logic e_oe, logic [11:0] e_ra,
                                     logic e_req, logic [11:0] e_xa, logic e_xrd,
                                     logic e_xwr, logic [7:0] e_do, logic e_flt);
    return {e_db, e_oe, e_ra, e_req, e_xa, e_xrd, e_xwr, e_do, e_flt};
  endfunction

  function automatic vec_t mk(string n, logic a, logic ps, logic rd, logic wr,
                              logic [7:0] d, logic [7:0] pg, logic rack, logic [7:0] rdat,
                              logic xack, logic [7:0] xdi, logic [44:0] e);
    vec_t v;
    v.name = n; v.ale = a; v.psen_n = ps; v.rd_n = rd; v.wr_n = wr;
    v.cpu_db = d; v.p2 = pg; v.rom_ack = rack; v.rom_d = rdat;
    v.xd_ack = xack; v.xd_di = xdi; v.exp = e;
    return v;
  endfunction

  function automatic logic [44:0] actual();
    return {db, db_oe, rom_a, rom_req, xd_a, xd_rd, xd_wr, xd_do, fault};
  endfunction

  task automatic check(string name, logic [44:0] exp);
    logic [44:0] act;
    act = actual();
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got db=%h oe=%b rom_a=%h req=%b xd_a=%h rd=%b wr=%b do=%h flt=%b ; want db=%h oe=%b rom_a=%h req=%b xd_a=%h rd=%b wr=%b do=%h flt=%b",
               name, act[44:37], act[36], act[35:24], act[23], act[22:11], act[10], act[9], act[8:1], act[0],
               exp[44:37], exp[36], exp[35:24], exp[23], exp[22:11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic drive(vec_t v);
    ale = v.ale; psen_n = v.psen_n; rd_n = v.rd_n; wr_n = v.wr_n;
    cpu_db = v.cpu_db; p2 = v.p2; rom_ack = v.rom_ack; rom_d = v.rom_d;
    xd_ack = v.xd_ack; xd_di = v.xd_di;
  endtask

  task automatic run_row(vec_t v);
    drive(v);
    @(negedge clk);
    check(v.name, v.exp);
  endtask

  logic [44:0] rst_vec;

  initial begin
    rst_vec = ex(8'hFF, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 8'h00, 1'b0);

    // Fetch: latch 3C / page 5, ack two clocks after REQ
    tbl.push_back(mk("f_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h3C,8'hF5, 1'b0,8'h00, 1'b0,8'h00, rst_vec));
    tbl.push_back(mk("f_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h3C,8'hF5, 1'b0,8'h00, 1'b0,8'h00, rst_vec));
    tbl.push_back(mk("f_fall",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'hF5, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b1,12'h000,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("f_wait",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'hF5, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b1,12'h000,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("f_ack",    1'b0,1'b0,1'b1,1'b1, 8'hFF,8'hF5, 1'b1,8'hA7, 1'b0,8'h00, ex(8'hA7,1'b1,12'h53C,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("f_hold", 1'b0,1'b0,1'b1,1'b1, 8'hFF,8'hF5, 1'b0,8'h00, 1'b0,8'h00, ex(8'hA7,1'b1,12'h53C,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("f_rise",   1'b0,1'b1,1'b1,1'b1, 8'hFF,8'hF5, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));

    // MOVX read from 210, with a stray ROM ack while holding
    tbl.push_back(mk("r_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h10,8'h02, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("r_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h10,8'h02, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("r_fall",   1'b0,1'b1,1'b0,1'b1, 8'hFF,8'h02, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h210,1'b1,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("r_ack",    1'b0,1'b1,1'b0,1'b1, 8'hFF,8'h02, 1'b0,8'h00, 1'b1,8'h5A, ex(8'h5A,1'b1,12'h53C,1'b0,12'h210,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("r_stray",  1'b0,1'b1,1'b0,1'b1, 8'hFF,8'h02, 1'b1,8'h99, 1'b0,8'h00, ex(8'h5A,1'b1,12'h53C,1'b0,12'h210,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("r_rise",   1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h02, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h210,1'b0,1'b0,8'h00,1'b0)));

    // MOVX write C3 to 081, ack three clocks after the WRn rise
    tbl.push_back(mk("w_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h81,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h210,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("w_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h81,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h210,1'b0,1'b0,8'h00,1'b0)));
    tbl.push_back(mk("w_fall",   1'b0,1'b1,1'b1,1'b0, 8'hC3,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("w_stray",  1'b0,1'b1,1'b1,1'b0, 8'hC3,8'h00, 1'b0,8'h00, 1'b1,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("w_rise",   1'b0,1'b1,1'b1,1'b1, 8'hEE,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b1,8'hC3,1'b0)));
    tbl.push_back(mk("w_wait1",  1'b0,1'b1,1'b1,1'b1, 8'hEE,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b1,8'hC3,1'b0)));
    tbl.push_back(mk("w_wait2",  1'b0,1'b1,1'b1,1'b1, 8'hEE,8'h00, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b1,8'hC3,1'b0)));
    tbl.push_back(mk("w_ack",    1'b0,1'b1,1'b1,1'b1, 8'hEE,8'h00, 1'b0,8'h00, 1'b1,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("w_idleack",1'b0,1'b1,1'b1,1'b1, 8'hEE,8'h00, 1'b0,8'h00, 1'b1,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));

    // Page change between ALE and PSENn must not affect the address
    tbl.push_back(mk("p_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h20,8'h01, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("p_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h20,8'h01, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("p_p2chg",  1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h07, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h53C,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("p_fall",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h07, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h120,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("p_ack",    1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h07, 1'b1,8'h5E, 1'b0,8'h00, ex(8'h5E,1'b1,12'h120,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("p_rise",   1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h07, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h120,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));

    // Late ack: PSENn ends before the ack, then a normal fetch
    tbl.push_back(mk("l_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h44,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h120,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("l_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h44,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h120,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("l_fall",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("l_wait",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b0)));
    tbl.push_back(mk("l_rise",   1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    tbl.push_back(mk("l_drain",  1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    tbl.push_back(mk("l_ack",    1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h03, 1'b1,8'h77, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    tbl.push_back(mk("l_refetch",1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    tbl.push_back(mk("l_reack",  1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h03, 1'b1,8'h12, 1'b0,8'h00, ex(8'h12,1'b1,12'h344,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    tbl.push_back(mk("l_rerise", 1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h03, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b1)));

    // After a mid-request reset: pending ack ignored, then a fresh fetch works
    for (int i = 0; i < 3; i++)
      post.push_back(mk("x_pendack", 1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h00, 1'b1,8'hAB, 1'b0,8'h00, rst_vec));
    post.push_back(mk("x_ale_hi", 1'b1,1'b1,1'b1,1'b1, 8'h9A,8'h0F, 1'b0,8'h00, 1'b0,8'h00, rst_vec));
    post.push_back(mk("x_ale_lo", 1'b0,1'b1,1'b1,1'b1, 8'h9A,8'h0F, 1'b0,8'h00, 1'b0,8'h00, rst_vec));
    post.push_back(mk("x_fall",   1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h0F, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'hF9A,1'b1,12'h000,1'b0,1'b0,8'h00,1'b0)));
    post.push_back(mk("x_ack",    1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h0F, 1'b1,8'h3D, 1'b0,8'h00, ex(8'h3D,1'b1,12'hF9A,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0)));
    post.push_back(mk("x_rise",   1'b0,1'b1,1'b1,1'b1, 8'hFF,8'h0F, 1'b0,8'h00, 1'b0,8'h00, rst_vec ^ {8'h00,1'b0,12'hF9A,1'b0,12'h000,1'b0,1'b0,8'h00,1'b0}));

    // Power-on reset
    rst_n = 1'b0;
    ale = 1'b0; psen_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    cpu_db = 8'h00; p2 = 8'h00; rom_ack = 1'b0; rom_d = 8'h00; xd_ack = 1'b0; xd_di = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("reset", rst_vec);
    rst_n = 1'b1;

    foreach (tbl[i]) run_row(tbl[i]);

    // Reset asserted while a ROM request is outstanding
    run_row(mk("x_ale_hi0", 1'b1,1'b1,1'b1,1'b1, 8'h55,8'h06, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    run_row(mk("x_ale_lo0", 1'b0,1'b1,1'b1,1'b1, 8'h55,8'h06, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h344,1'b0,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    run_row(mk("x_req",     1'b0,1'b0,1'b1,1'b1, 8'hFF,8'h06, 1'b0,8'h00, 1'b0,8'h00, ex(8'hFF,1'b0,12'h655,1'b1,12'h081,1'b0,1'b0,8'hC3,1'b1)));
    #2 rst_n = 1'b0;
    #1 check("x_async_rst", rst_vec);
    psen_n = 1'b1; rom_ack = 1'b1; rom_d = 8'hAB;
    @(negedge clk);
    check("x_in_rst", rst_vec);
    rst_n = 1'b1;
    foreach (post[i]) run_row(post[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
